// File: rtl/cholesky_pkg.sv
// Shared definitions for the Cholesky / forward-substitution datapath:
// matrix dimension, word width, matrix/vector types, FSM states and the
// saturation helper used by the accumulators.
package cholesky_pkg;

    localparam int N     = 6;
    localparam int W     = 36;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = 4;

    localparam int DEF_MULT_LAT = 4;
    localparam int DEF_DIV_LAT  = 6;

    typedef logic [W-1:0]        word_t;
    typedef word_t [N-1:0]       vec_t;
    typedef vec_t  [N-1:0]       mat_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_SUB,
        S_DIV,
        S_WB,
        S_DONE
    } fs_state_t;

    // Clamp a W+1 bit two's-complement result to the signed W-bit range.
    function automatic word_t sat_word(input logic [W:0] v);
        if (v[W] != v[W-1]) begin
            return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return v[W-1:0];
    endfunction

endpackage

// File: rtl/fs_lat_counter.sv
// Loadable down-counter with enable gating. Times the MAC drain and the
// divider wait of the forward-substitution FSM; stops at zero.
module fs_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Load takes priority over counting; everything freezes while en is low.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <=, so every
        // register samples its inputs from before the clock edge.
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            if (load) begin
                count <= load_val;
            end else if (count != '0) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/forward_subst_block.sv
// Forward substitution: solves lt*y = rhs for a 6x6 lower-triangular lt.
// Products and quotients come from one lane of the external shared
// multiplier/divider arrays via fixed-latency ports.
// Optional feature: define FWD_SUBST_DIV0_CHECK_EN to skip the divider on a
// zero diagonal, write y[i]=0 and raise the sticky err flag.
module forward_subst_block
    import cholesky_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        start,
    input  logic [N-1:0][N-1:0][W-1:0]  lt,
    input  logic [N-1:0][W-1:0]         rhs,
    output logic [W-1:0]                mult_dataa,
    output logic [W-1:0]                mult_datab,
    input  logic [W-1:0]                mult_result,
    output logic [W-1:0]                div_dividend,
    output logic [W-1:0]                div_divisor,
    input  logic [W-1:0]                div_quotient,
    output logic                        busy,
    output logic                        done,
    output logic [N-1:0][W-1:0]         y,
    output logic                        err
);

    fs_state_t        state;
    mat_t             lt_q;
    vec_t             rhs_q;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] iss_j;
    word_t            acc;
    logic             div0_q;

    logic [IDX_W-1:0] row_nx;
    logic [IDX_W-1:0] iss_nx;
    logic [W:0]       acc_sum;
    logic [W:0]       num_diff;
    word_t            wb_val;
    logic             div0_now;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    fs_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (cnt_load),
        .load_val (cnt_val),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Snapshot of the operands taken in LOAD; later input changes are ignored.
    always_ff @(posedge clk) begin
        // NOTE: these are pure data holders rewritten on every LOAD before
        // use, so they carry no reset.
        if (en && state == S_LOAD) begin
            lt_q  <= lt;
            rhs_q <= rhs;
        end
    end

    // Datapath arithmetic and latency-counter load requests.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        cnt_load = 1'b0;
        cnt_val  = '0;
        row_nx   = row + IDX_W'(1);
        iss_nx   = iss_j + IDX_W'(1);
        acc_sum  = {acc[W-1], acc} + {mult_result[W-1], mult_result};
        num_diff = {rhs_q[row][W-1], rhs_q[row]} - {acc[W-1], acc};
        wb_val   = div0_q ? '0 : div_quotient;
`ifdef FWD_SUBST_DIV0_CHECK_EN
        div0_now = (lt_q[row][row] == '0);
`else
        div0_now = 1'b0;
`endif
        case (state)
            S_WB: begin
                // MAC of row i+1 lasts (i+1)+MULT_LAT cycles.
                if (row != IDX_W'(N-1)) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(row) + CNT_W'(MULT_LAT);
                end
            end
            S_SUB: begin
                if (!div0_now) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(DIV_LAT - 1);
                end
            end
            default: ;
        endcase
    end

    // Main FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            row          <= '0;
            iss_j        <= '0;
            acc          <= '0;
            div0_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            y            <= '0;
            mult_dataa   <= '0;
            mult_datab   <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
`ifdef FWD_SUBST_DIV0_CHECK_EN
            err          <= 1'b0;
`endif
        end else if (en) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    row    <= '0;
                    acc    <= '0;
                    div0_q <= 1'b0;
`ifdef FWD_SUBST_DIV0_CHECK_EN
                    err    <= 1'b0;
`endif
                    // Row 0 has no products to accumulate.
                    state  <= S_SUB;
                end
                S_MAC: begin
                    // Product j was issued in MAC cycle j and returns in cycle
                    // j+MULT_LAT, i.e. while the counter is below the row index.
                    if (cnt < CNT_W'(row)) begin
                        acc <= sat_word(acc_sum);
                    end
                    if (iss_nx < row) begin
                        mult_dataa <= lt_q[row][iss_nx];
                        mult_datab <= y[iss_nx];
                        iss_j      <= iss_nx;
                    end else begin
                        mult_dataa <= '0;
                        mult_datab <= '0;
                    end
                    if (cnt_zero) begin
                        state <= S_SUB;
                    end
                end
                S_SUB: begin
                    div0_q <= div0_now;
                    if (div0_now) begin
                        state <= S_WB;
                    end else begin
                        div_dividend <= sat_word(num_diff);
                        div_divisor  <= lt_q[row][row];
                        state        <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (cnt_zero) begin
                        div_dividend <= '0;
                        div_divisor  <= '0;
                        state        <= S_WB;
                    end
                end
                S_WB: begin
                    y[row] <= wb_val;
`ifdef FWD_SUBST_DIV0_CHECK_EN
                    if (div0_q) begin
                        err <= 1'b1;
                    end
`endif
                    if (row == IDX_W'(N-1)) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        // Issue product j=0 of the next row on entry to MAC;
                        // y[0] is still being written when leaving row 0.
                        row        <= row_nx;
                        acc        <= '0;
                        iss_j      <= '0;
                        mult_dataa <= lt_q[row_nx][0];
                        mult_datab <= (row == '0) ? wb_val : y[0];
                        state      <= S_MAC;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef FWD_SUBST_DIV0_CHECK_EN
    assign err = 1'b0;
`endif

endmodule
